// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet framer and clamped absolute-position tracker.
// Optional 4-byte IntelliMouse framing with wheel output when PS2_WHEEL_EN is defined.
module ps2_mouse_tracker #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int POS_W       = 10,
    parameter int Y_INVERT    = 1,
    parameter int TIMEOUT_CYC = 54000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_error,
    input  logic             recenter,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic [8:0]       delta_x,
    output logic [8:0]       delta_y,
    output logic [2:0]       buttons,
`ifdef PS2_WHEEL_EN
    output logic [3:0]       wheel_delta,
`endif
    output logic             packet_valid,
    output logic             sync_error
);

    // state | meaning
    // HDR   | waiting for a header byte (bit 3 set)
    // BX    | waiting for the X delta byte
    // BY    | waiting for the Y delta byte
    // BZ    | waiting for the wheel byte (wheel builds only)
    // UPD   | one cycle: registered outputs and position update
    typedef enum logic [2:0] {
        HDR,
        BX,
        BY,
`ifdef PS2_WHEEL_EN
        BZ,
`endif
        UPD
    } state_t;

    localparam int SW    = POS_W + 2;
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [TMR_W-1:0]    TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [POS_W-1:0]    X_CTR    = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0]    Y_CTR    = POS_W'(Y_MAX / 2);
    localparam logic [POS_W-1:0]    X_MAX_P  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]    Y_MAX_P  = POS_W'(Y_MAX);
    localparam logic signed [SW-1:0] X_MAX_S = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_MAX_S = SW'(Y_MAX);

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic               sync_err_nxt;
    logic               abort;
    logic               byte_ok;

    // header stored without bit 3: {y_ovf, x_ovf, y_sign, x_sign, M, R, L}
    logic [6:0]         hdr_q;
    logic [7:0]         bx_q;
    logic [7:0]         by_q;
`ifdef PS2_WHEEL_EN
    logic [3:0]         bz_q;
`endif

    logic [8:0]         dx_now;
    logic [8:0]         dy_now;
    logic signed [SW-1:0] dx_ext;
    logic signed [SW-1:0] dy_ext;
    logic signed [SW-1:0] px_ext;
    logic signed [SW-1:0] py_ext;
    logic signed [SW-1:0] nx;
    logic signed [SW-1:0] ny;
    logic [POS_W-1:0]   x_clamped;
    logic [POS_W-1:0]   y_clamped;

    assign byte_ok = rx_ready & ~rx_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr;
        sync_err_nxt = 1'b0;
        abort        = 1'b0;
        case (state)
            HDR: begin
                tmr_nxt = '0;
                if (rx_error) begin
                    sync_err_nxt = 1'b1;
                end else if (rx_ready) begin
                    if (rx_data[3]) begin
                        state_nxt = BX;
                        tmr_nxt   = TMR_LOAD;
                    end else begin
                        sync_err_nxt = 1'b1;
                    end
                end
            end
            BX, BY
`ifdef PS2_WHEEL_EN
            , BZ
`endif
            : begin
                if (rx_error || (!rx_ready && tmr == '0)) begin
                    abort = 1'b1;
                end else if (rx_ready) begin
                    tmr_nxt = TMR_LOAD;
                    case (state)
                        BX:      state_nxt = BY;
`ifdef PS2_WHEEL_EN
                        BY:      state_nxt = BZ;
`else
                        BY:      state_nxt = UPD;
`endif
                        default: state_nxt = UPD;
                    endcase
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            UPD: begin
                state_nxt = HDR;
                tmr_nxt   = '0;
            end
            default: begin
                state_nxt = HDR;
                tmr_nxt   = '0;
            end
        endcase
        if (abort) begin
            state_nxt    = HDR;
            tmr_nxt      = '0;
            sync_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q <= '0;
            bx_q  <= '0;
            by_q  <= '0;
`ifdef PS2_WHEEL_EN
            bz_q  <= '0;
`endif
        end else if (byte_ok) begin
            case (state)
                HDR: if (rx_data[3]) hdr_q <= {rx_data[7:4], rx_data[2:0]};
                BX:  bx_q <= rx_data;
                BY:  by_q <= rx_data;
`ifdef PS2_WHEEL_EN
                BZ:  bz_q <= rx_data[3:0];
`endif
                default: ;
            endcase
        end
    end

    // An overflowed axis contributes a zero delta, which leaves its position as is.
    assign dx_now = hdr_q[5] ? 9'd0 : {hdr_q[3], bx_q};
    assign dy_now = hdr_q[6] ? 9'd0 : {hdr_q[4], by_q};
    assign dx_ext = SW'($signed(dx_now));
    assign dy_ext = SW'($signed(dy_now));
    assign px_ext = $signed({2'b00, pos_x});
    assign py_ext = $signed({2'b00, pos_y});
    assign nx     = px_ext + dx_ext;
    assign ny     = (Y_INVERT != 0) ? (py_ext - dy_ext) : (py_ext + dy_ext);

    always_comb begin
        x_clamped = nx[POS_W-1:0];
        if (nx[SW-1]) begin
            x_clamped = '0;
        end else if (nx > X_MAX_S) begin
            x_clamped = X_MAX_P;
        end
        y_clamped = ny[POS_W-1:0];
        if (ny[SW-1]) begin
            y_clamped = '0;
        end else if (ny > Y_MAX_S) begin
            y_clamped = Y_MAX_P;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_x        <= X_CTR;
            pos_y        <= Y_CTR;
            delta_x      <= '0;
            delta_y      <= '0;
            buttons      <= '0;
`ifdef PS2_WHEEL_EN
            wheel_delta  <= '0;
`endif
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
        end else begin
            packet_valid <= (state == UPD);
            sync_error   <= sync_err_nxt;
            if (state == UPD) begin
                delta_x     <= dx_now;
                delta_y     <= dy_now;
                buttons     <= hdr_q[2:0];
`ifdef PS2_WHEEL_EN
                wheel_delta <= bz_q;
`endif
            end
            if (recenter) begin
                pos_x <= X_CTR;
                pos_y <= Y_CTR;
            end else if (state == UPD) begin
                pos_x <= x_clamped;
                pos_y <= y_clamped;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: packet table plus hand-written abort/timeout/recenter sequences,
// with a scoreboard checked whenever packet_valid pulses.
module tb_ps2_mouse_tracker;

    localparam int TO = 40;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic       recenter;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [8:0] delta_x;
    logic [8:0] delta_y;
    logic [2:0] buttons;
`ifdef PS2_WHEEL_EN
    logic [3:0] wheel_delta;
`endif
    logic       packet_valid;
    logic       sync_error;

    ps2_mouse_tracker #(.TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_error    (rx_error),
        .recenter    (recenter),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .delta_x     (delta_x),
        .delta_y     (delta_y),
        .buttons     (buttons),
`ifdef PS2_WHEEL_EN
        .wheel_delta (wheel_delta),
`endif
        .packet_valid(packet_valid),
        .sync_error  (sync_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rc;
        logic [7:0] b0, b1, b2, b3;
        logic [8:0] dx, dy;
        logic [2:0] btn;
        int         x, y;
        logic [3:0] w;
    } vec_t;

    typedef struct {
        logic [8:0] dx, dy;
        logic [2:0] btn;
        int         x, y;
        logic [3:0] w;
        int         cyc;
    } exp_t;

    vec_t tbl[17];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sync_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (sync_error) sync_cnt++;
        if (packet_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_packet_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pv_latency", cyc, e.cyc);
                chk("delta_x", int'(delta_x), int'(e.dx));
                chk("delta_y", int'(delta_y), int'(e.dy));
                chk("buttons", int'(buttons), int'(e.btn));
                chk("pos_x", int'(pos_x), e.x);
                chk("pos_y", int'(pos_y), e.y);
`ifdef PS2_WHEEL_EN
                chk("wheel_delta", int'(wheel_delta), int'(e.w));
`endif
            end
        end
    end

    // Called just after a falling edge; returns just after a falling edge with
    // exactly `gap` idle cycles seen by the DUT after the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input exp_t e, input bit rc_upd);
        logic [7:0] last;
        exp_t       ee;
        send_byte(b0, 2);
        send_byte(b1, 2);
`ifdef PS2_WHEEL_EN
        send_byte(b2, 2);
        last = b3;
`else
        last = b2;
`endif
        ee     = e;
        ee.cyc = cyc + 2;
        sb.push_back(ee);
        rx_data  = last;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        recenter = rc_upd;
        @(negedge clk);
        recenter = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_recenter();
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [8:0] dx, input logic [8:0] dy, input logic [2:0] btn,
                                input int x, input int y, input logic [3:0] w);
        exp_t e;
        e.dx = dx; e.dy = dy; e.btn = btn; e.x = x; e.y = y; e.w = w; e.cyc = 0;
        return e;
    endfunction

    initial begin
        int   s0;
        int   kk;
        bit   found;
        exp_t e;

        tbl[0]  = '{0, 8'h08, 8'h05, 8'h05, 8'h0F, 9'h005, 9'h005, 3'd0, 324, 234, 4'hF};
        tbl[1]  = '{0, 8'h3F, 8'hF9, 8'hF9, 8'h00, 9'h1F9, 9'h1F9, 3'd7, 317, 241, 4'h0};
        tbl[2]  = '{1, 8'h08, 8'h7F, 8'h00, 8'h01, 9'h07F, 9'h000, 3'd0, 446, 239, 4'h1};
        tbl[3]  = '{0, 8'h08, 8'h7F, 8'h00, 8'h00, 9'h07F, 9'h000, 3'd0, 573, 239, 4'h0};
        tbl[4]  = '{0, 8'h08, 8'h7F, 8'h00, 8'h00, 9'h07F, 9'h000, 3'd0, 639, 239, 4'h0};
        tbl[5]  = '{0, 8'h08, 8'h7F, 8'h00, 8'h00, 9'h07F, 9'h000, 3'd0, 639, 239, 4'h0};
        tbl[6]  = '{0, 8'h08, 8'h7F, 8'h00, 8'h00, 9'h07F, 9'h000, 3'd0, 639, 239, 4'h0};
        tbl[7]  = '{0, 8'h08, 8'h7F, 8'h00, 8'h00, 9'h07F, 9'h000, 3'd0, 639, 239, 4'h0};
        tbl[8]  = '{0, 8'h08, 8'h7F, 8'h00, 8'h00, 9'h07F, 9'h000, 3'd0, 639, 239, 4'h0};
        tbl[9]  = '{0, 8'h08, 8'h7F, 8'h00, 8'h00, 9'h07F, 9'h000, 3'd0, 639, 239, 4'h0};
        tbl[10] = '{1, 8'h18, 8'h00, 8'h00, 8'h00, 9'h100, 9'h000, 3'd0, 63, 239, 4'h0};
        tbl[11] = '{0, 8'h18, 8'h00, 8'h00, 8'h00, 9'h100, 9'h000, 3'd0, 0, 239, 4'h0};
        tbl[12] = '{0, 8'h28, 8'h00, 8'h00, 8'h00, 9'h000, 9'h100, 3'd0, 0, 479, 4'h0};
        tbl[13] = '{0, 8'h08, 8'h01, 8'hFF, 8'h00, 9'h001, 9'h0FF, 3'd0, 1, 224, 4'h0};
        tbl[14] = '{0, 8'h08, 8'h00, 8'hFF, 8'h00, 9'h000, 9'h0FF, 3'd0, 1, 0, 4'h0};
        tbl[15] = '{1, 8'h48, 8'h10, 8'h02, 8'h00, 9'h000, 9'h002, 3'd0, 319, 237, 4'h0};
        tbl[16] = '{0, 8'h8D, 8'h05, 8'h05, 8'h00, 9'h005, 9'h000, 3'd5, 324, 237, 4'h0};

        rst = 1'b1; rx_data = 8'h00; rx_ready = 1'b0; rx_error = 1'b0; recenter = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_pos_x", int'(pos_x), 319);
        chk("reset_pos_y", int'(pos_y), 239);
        chk("reset_delta_x", int'(delta_x), 0);
        chk("reset_delta_y", int'(delta_y), 0);
        chk("reset_buttons", int'(buttons), 0);
        chk("reset_packet_valid", int'(packet_valid), 0);
        chk("reset_sync_error", int'(sync_error), 0);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rc) pulse_recenter();
            e = mk(tbl[i].dx, tbl[i].dy, tbl[i].btn, tbl[i].x, tbl[i].y, tbl[i].w);
            send_pkt(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, e, 1'b0);
        end

        pulse_recenter();
        chk("recenter_pos_x", int'(pos_x), 319);
        chk("recenter_pos_y", int'(pos_y), 239);

        // Header with bit 3 clear is rejected.
        s0 = sync_cnt;
        send_byte(8'h00, 3);
        chk("resync_pulse", sync_cnt, s0 + 1);
        send_pkt(8'h09, 8'h02, 8'h03, 8'h00, mk(9'h002, 9'h003, 3'd1, 321, 236, 4'h0), 1'b0);

        // Parity error after the header aborts with outputs held.
        s0 = sync_cnt;
        send_byte(8'h08, 1);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("parity_abort_pulse", sync_cnt, s0 + 1);
        chk("parity_hold_pos_x", int'(pos_x), 321);
        chk("parity_hold_delta_x", int'(delta_x), 2);
        chk("parity_hold_buttons", int'(buttons), 1);
        send_pkt(8'h0A, 8'h01, 8'h01, 8'h00, mk(9'h001, 9'h001, 3'd2, 322, 235, 4'h0), 1'b0);

        // Timeout fires after exactly TO idle cycles in BX.
        found = 1'b0;
        kk = -1;
        send_byte(8'h08, 0);
        for (int k = 1; k <= TO + 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (sync_error) begin
                found = 1'b1;
                kk = k;
            end
        end
        @(negedge clk);
        chk("timeout_cycles", kk, TO);
        repeat (2) @(negedge clk);
        chk("timeout_hold_delta_x", int'(delta_x), 1);

        // A byte arriving on the last allowed idle cycle is still accepted.
        send_byte(8'h08, TO - 1);
        send_byte(8'h03, 2);
        sb.push_back('{9'h003, 9'h000, 3'd0, 325, 235, 4'h0, cyc + 2});
`ifdef PS2_WHEEL_EN
        send_byte(8'h00, 2);
        sb[sb.size()-1].cyc = cyc + 2;
`endif
        send_byte(8'h00, 5);

        // Recenter in the UPD cycle wins for position only.
        send_pkt(8'h08, 8'h20, 8'h10, 8'h00, mk(9'h020, 9'h010, 3'd0, 319, 239, 4'h0), 1'b1);

        // rx_error coincident with rx_ready drops the byte and aborts.
        s0 = sync_cnt;
        send_byte(8'h08, 1);
        rx_data  = 8'h05;
        rx_ready = 1'b1;
        rx_error = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_error = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_with_ready_pulse", sync_cnt, s0 + 1);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h00, mk(9'h001, 9'h001, 3'd0, 320, 238, 4'h0), 1'b0);

        // Reset mid-packet: no sync_error, state back to reset values.
        s0 = sync_cnt;
        send_byte(8'h09, 2);
        send_byte(8'h05, 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mid_no_sync", sync_cnt, s0);
        chk("reset_mid_pos_x", int'(pos_x), 319);
        chk("reset_mid_buttons", int'(buttons), 0);
        send_pkt(8'h08, 8'h05, 8'h05, 8'h00, mk(9'h005, 9'h005, 3'd0, 324, 234, 4'h0), 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_tracker.md
# ps2_mouse_tracker

Parametrised PS/2 mouse packet framer and absolute-position tracker. It sits downstream of `ps2_receiver` and consumes its `rx_data`/`rx_ready`/`rx_error` byte stream once mouse initialisation has reached stream mode. It frames 3-byte standard or 4-byte wheel packets, resynchronises on bad framing, parity errors and inter-byte timeouts, and accumulates deltas into a clamped screen position. Cursor and UI logic consume its outputs directly.

## Interface
- `X_MAX`, 639: maximum X position, inclusive; the minimum is 0.
- `Y_MAX`, 479: maximum Y position, inclusive.
- `POS_W`, 10: width of the position outputs; `X_MAX` and `Y_MAX` must each be ≤ 2^POS_W−1.
- `Y_INVERT`, 1: 1 means a PS/2 +Y (up) decreases `pos_y` (screen coordinates); 0 means it adds.
- `TIMEOUT_CYC`, 54000: idle cycles allowed between bytes of one packet (2 ms at 27 MHz).
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `rx_data` input 8: byte from `ps2_receiver`.
- `rx_ready` input 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_error` input 1: one-cycle strobe for a parity or framing error.
- `recenter` input 1: pulse; forces the position to (`X_MAX`/2, `Y_MAX`/2).
- `pos_x`, `pos_y` output POS_W: accumulated, clamped position.
- `delta_x`, `delta_y` output 9: signed deltas of the last accepted packet.
- `buttons` output 3: {M, R, L} from the last accepted packet.
- `wheel_delta` output 4: signed Z of the last packet; only present with `PS2_WHEEL_EN`.
- `packet_valid` output 1: one-cycle pulse when outputs update.
- `sync_error` output 1: one-cycle pulse whenever a packet is aborted or a header is rejected.

## Operation
- **States.** `HDR`, `BX`, `BY`, `BZ` (wheel builds only), `UPD`.
- **`HDR`.**
  - On `rx_ready`, if `rx_data[3]==1`, latch the header and go to `BX`.
  - If `rx_data[3]==0`, stay in `HDR` and pulse `sync_error`. The byte is discarded; this is the resync path.
- **`BX` → `BY`.** Each state latches its byte on `rx_ready`.
- **Leaving `BY`.** Go to `BZ` in wheel builds, otherwise to `UPD`. `BZ` latches `rx_data[3:0]` and goes to `UPD`.
- **`UPD`** lasts exactly one cycle, then returns to `HDR`. In that cycle:
  - Form `delta_x = {hdr[4], bx}` and `delta_y = {hdr[5], by}`.
  - Set `buttons = hdr[2:0]`.
  - Pulse `packet_valid`.
- **Overflow.** If `hdr[6]` (X overflow) or `hdr[7]` (Y overflow) is set, the matching delta output is forced to 0 and that axis's position is unchanged. Buttons still update.
- **Position arithmetic.**
  - Compute in signed POS_W+2 bits: `nx = pos_x + delta_x`, and `ny = pos_y − delta_y` (or `+ delta_y` when `Y_INVERT=0`).
  - Clamp each to [0, MAX]. A result below 0 gives 0; a result above MAX gives MAX.
- **Abort mid-packet.** In `BX`, `BY` or `BZ`, either of these returns the FSM to `HDR`, pulses `sync_error`, and leaves all outputs unchanged:
  - `rx_error`;
  - `TIMEOUT_CYC` consecutive cycles with no `rx_ready`.
- **Timeout counter.** Clears on every accepted byte and on entry to `HDR`. It does not count in `HDR`.
- **Simultaneous events.**
  - `rx_error` together with `rx_ready`: the error wins and the byte is dropped.
  - `rx_error` in `HDR`: pulse `sync_error` and stay in `HDR`.
  - `recenter` in the `UPD` cycle: `recenter` wins for the position. Deltas and buttons still update and `packet_valid` still pulses.
  - `recenter` in any other state: the position loads the centre next cycle. The FSM is not disturbed.

## Timing
- **Reset values.** `pos_x = X_MAX/2` and `pos_y = Y_MAX/2` (integer division). All other outputs are 0. The FSM is in `HDR` and the timeout counter is 0.
- **Reset mid-packet.** Partial bytes are discarded; no `sync_error` pulse.
- **Latency.** `rx_ready` for the final byte in cycle N → `UPD` in N+1 → all outputs registered and `packet_valid` high in N+2. Outputs hold until the next `UPD`.
- **Pulse timing.** `sync_error` is registered: high in the cycle after the triggering condition, and for one cycle only.
- **Throughput.** `rx_ready` arriving during `UPD` is not accepted. `ps2_receiver` byte spacing is ≥ 11 PS/2 clocks, so there is no loss in practice.

## Configuration
- **Macro:** `PS2_WHEEL_EN`.
- **Defined:**
  - Packets are 4 bytes and the FSM includes `BZ`.
  - `wheel_delta` is the sign-extended `bz[3:0]`, updated in `UPD`; it resets to 0.
  - The upstream init sequence is responsible for enabling IntelliMouse mode.
- **Undefined:** packets are 3 bytes, the `BZ` state and `wheel_delta` port are absent, and the `BY` state goes directly to `UPD`.

## Test plan
- **Basic packet.** After reset, send packet 0x08, 0x05, 0x05 → `delta_x = +5`, `delta_y = +5`, `buttons = 000`, `pos = (324, 234)`, one `packet_valid`.
- **Negative deltas and buttons.** Send 0x3F, 0xF9, 0xF9 (−7, −7, all buttons) → `buttons = 111`, and `pos_x` decreases by 7 while `pos_y` increases by 7.
- **Clamping.** Send eight packets of X = +127 from reset → `pos_x` saturates at 639 and never wraps. Then `recenter` → `pos_x = 319`.
- **Header resync.** Send 0x00 → `sync_error` pulse, FSM stays in `HDR`. A valid packet sent next decodes correctly.
- **Parity error abort.** After a header byte, drive `rx_error` → no `packet_valid`, outputs unchanged. A following full packet decodes correctly.
- **Timeout and overflow.**
  - Send a header, then wait `TIMEOUT_CYC` cycles → `sync_error` pulse.
  - Send 0x48, 0x10, 0x02 → `delta_x = 0`, `delta_y = +2`.
  - With `PS2_WHEEL_EN`: a Z byte of 0x0F gives `wheel_delta = −1`.
